// File: rtl/ex_stage_mc.sv
// Multi-cycle execute stage: valid/allow handshake, ALU, multiply, iterative
// restoring divider, byte-lane store generation and forwarding info for decode.
module ex_stage_mc #(
  parameter int XLEN  = 32,
  parameter int IN_W  = 4*XLEN+26,
  parameter int OUT_W = 2*XLEN+12
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               valid_in,
  output logic               allow_in,
  input  logic [IN_W-1:0]    stage_in,
  output logic               valid_out,
  input  logic               allow_out,
  output logic [OUT_W-1:0]   stage_out,
  output logic               data_sram_en,
  output logic [XLEN/8-1:0]  data_sram_we,
  output logic [XLEN-1:0]    data_sram_addr,
  output logic [XLEN-1:0]    data_sram_wdata,
  output logic               fwd_valid,
  output logic [4:0]         fwd_dest,
  output logic               fwd_is_load,
  output logic [XLEN-1:0]    fwd_data
);
  localparam int LW = XLEN/8;
  localparam int AW = $clog2(LW);
  localparam int CW = $clog2(XLEN);
  localparam int SW = $clog2(XLEN);
  localparam logic [CW-1:0] CNT_LAST = CW'(XLEN-1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic            r_valid;
  logic [IN_W-1:0] r_payload;
  logic [1:0]      r_state;
  logic [CW-1:0]   r_cnt;
  logic [XLEN-1:0] r_rem, r_quo, r_div_res;

  logic [XLEN-1:0] w_pc, w_sd, w_src1, w_src2;
  logic            w_mem_en, w_mem_we, w_res_from_mem, w_rf_we;
  logic [1:0]      w_mem_size;
  logic [2:0]      w_md_op;
  logic [11:0]     w_alu_op;
  logic [4:0]      w_dest;

  assign w_pc           = r_payload[XLEN-1:0];
  assign w_sd           = r_payload[2*XLEN-1:XLEN];
  assign w_mem_en       = r_payload[2*XLEN];
  assign w_mem_size     = r_payload[2*XLEN+2:2*XLEN+1];
  assign w_mem_we       = r_payload[2*XLEN+3];
  assign w_md_op        = r_payload[2*XLEN+6:2*XLEN+4];
  assign w_alu_op       = r_payload[2*XLEN+18:2*XLEN+7];
  assign w_src2         = r_payload[3*XLEN+18:2*XLEN+19];
  assign w_src1         = r_payload[4*XLEN+18:3*XLEN+19];
  assign w_res_from_mem = r_payload[4*XLEN+19];
  assign w_dest         = r_payload[4*XLEN+24:4*XLEN+20];
  assign w_rf_we        = r_payload[4*XLEN+25];

  logic w_is_div, w_ready_go, w_capture;
  assign w_is_div   = w_md_op[2];
  assign w_ready_go = ~w_is_div | (r_state == S_DONE);
  assign allow_in   = ~r_valid | (w_ready_go & allow_out);
  assign w_capture  = valid_in & allow_in;
  assign valid_out  = r_valid & w_ready_go & ~flush;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid   <= 1'b0;
      r_payload <= '0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (w_capture) begin
      r_valid   <= 1'b1;
      r_payload <= stage_in;
    end else if (w_ready_go & allow_out) begin
      r_valid <= 1'b0;
    end
  end

  // ALU opcode is one-hot: add sub slt sltu and nor or xor sll srl sra lui
  logic [SW-1:0]   w_shamt;
  logic [XLEN-1:0] w_sra, w_alu_res;
  assign w_shamt = w_src2[SW-1:0];
  assign w_sra   = $signed(w_src1) >>> w_shamt;

  always_comb begin
    w_alu_res = '0;
    if (w_alu_op[0])  w_alu_res = w_alu_res | (w_src1 + w_src2);
    if (w_alu_op[1])  w_alu_res = w_alu_res | (w_src1 - w_src2);
    if (w_alu_op[2])  w_alu_res = w_alu_res | {{(XLEN-1){1'b0}}, $signed(w_src1) < $signed(w_src2)};
    if (w_alu_op[3])  w_alu_res = w_alu_res | {{(XLEN-1){1'b0}}, w_src1 < w_src2};
    if (w_alu_op[4])  w_alu_res = w_alu_res | (w_src1 & w_src2);
    if (w_alu_op[5])  w_alu_res = w_alu_res | ~(w_src1 | w_src2);
    if (w_alu_op[6])  w_alu_res = w_alu_res | (w_src1 | w_src2);
    if (w_alu_op[7])  w_alu_res = w_alu_res | (w_src1 ^ w_src2);
    if (w_alu_op[8])  w_alu_res = w_alu_res | (w_src1 << w_shamt);
    if (w_alu_op[9])  w_alu_res = w_alu_res | (w_src1 >> w_shamt);
    if (w_alu_op[10]) w_alu_res = w_alu_res | w_sra;
    if (w_alu_op[11]) w_alu_res = w_alu_res | w_src2;
  end

  // One 2*XLEN multiplier serves all three: low bits are extension-agnostic
  logic              w_mext;
  logic [2*XLEN-1:0] w_prod;
  assign w_mext = (w_md_op == 3'd2);
  assign w_prod = {{XLEN{w_mext & w_src1[XLEN-1]}}, w_src1}
                * {{XLEN{w_mext & w_src2[XLEN-1]}}, w_src2};

  logic            w_sgn, w_a_neg, w_b_neg;
  logic [XLEN-1:0] w_amag, w_bmag, w_rem_src, w_quo_src, w_rem_n, w_quo_n;
  logic [XLEN-1:0] w_quo_fix, w_rem_fix, w_div_final;
  logic [XLEN:0]   w_shift, w_diff;
  assign w_sgn     = ~w_md_op[1];
  assign w_a_neg   = w_sgn & w_src1[XLEN-1];
  assign w_b_neg   = w_sgn & w_src2[XLEN-1];
  assign w_amag    = w_a_neg ? -w_src1 : w_src1;
  assign w_bmag    = w_b_neg ? -w_src2 : w_src2;
  assign w_rem_src = (r_cnt == '0) ? '0 : r_rem;
  assign w_quo_src = (r_cnt == '0) ? w_amag : r_quo;
  assign w_shift   = {w_rem_src, w_quo_src[XLEN-1]};
  assign w_diff    = w_shift - {1'b0, w_bmag};
  assign w_rem_n   = w_diff[XLEN] ? w_shift[XLEN-1:0] : w_diff[XLEN-1:0];
  assign w_quo_n   = {w_quo_src[XLEN-2:0], ~w_diff[XLEN]};
  assign w_quo_fix = (w_a_neg ^ w_b_neg) ? -w_quo_n : w_quo_n;
  assign w_rem_fix = w_a_neg ? -w_rem_n : w_rem_n;
  assign w_div_final = (w_src2 == '0) ? (w_md_op[0] ? w_src1 : '1)
                                      : (w_md_op[0] ? w_rem_fix : w_quo_fix);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_rem     <= '0;
      r_quo     <= '0;
      r_div_res <= '0;
    end else if (flush) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else if (w_capture) begin
      r_state <= stage_in[2*XLEN+6] ? S_BUSY : S_IDLE;
      r_cnt   <= '0;
    end else if (r_state == S_BUSY) begin
      r_rem <= w_rem_n;
      r_quo <= w_quo_n;
      r_cnt <= r_cnt + 1'b1;
      if (r_cnt == CNT_LAST) begin
        r_state   <= S_DONE;
        r_div_res <= w_div_final;
      end
    end else if ((r_state == S_DONE) && allow_out) begin
      r_state <= S_IDLE;
    end
  end

  logic [XLEN-1:0] w_result;
  always_comb begin
    case (w_md_op)
      3'd0:    w_result = w_alu_res;
      3'd1:    w_result = w_prod[XLEN-1:0];
      3'd2,
      3'd3:    w_result = w_prod[2*XLEN-1:XLEN];
      default: w_result = r_div_res;
    endcase
  end

  logic [AW-1:0]   w_alo;
  logic [LW-1:0]   w_we;
  logic [XLEN-1:0] w_wdata;
  logic            w_ale;
  assign w_alo = w_result[AW-1:0];

  always_comb begin
    w_we    = '1;
    w_wdata = w_sd;
    w_ale   = 1'b0;
    case (w_mem_size)
      2'd0: begin
        w_we    = LW'(1) << w_alo;
        w_wdata = {LW{w_sd[7:0]}};
      end
      2'd1: begin
        w_we    = LW'(3) << (w_alo & ~AW'(1));
        w_wdata = {(LW/2){w_sd[15:0]}};
        w_ale   = w_alo[0];
      end
      2'd2: begin
        w_we    = LW'(15) << (w_alo & ~AW'(3));
        w_wdata = {(LW/4){w_sd[31:0]}};
        w_ale   = |w_alo[1:0];
      end
      default: w_ale = |w_alo;
    endcase
  end

  logic w_ale_q;
  assign w_ale_q = w_mem_en & w_ale;

  assign data_sram_en    = r_valid & w_mem_en & ~w_ale_q & allow_out & ~flush;
  assign data_sram_we    = w_mem_we ? w_we : '0;
  assign data_sram_addr  = w_result;
  assign data_sram_wdata = w_wdata;

  assign stage_out = {w_rf_we, w_dest, w_res_from_mem, w_mem_size,
                      w_result[1:0], w_ale_q, w_result, w_pc};

  assign fwd_valid   = r_valid & w_rf_we & (w_dest != 5'd0);
  assign fwd_dest    = w_dest;
  assign fwd_is_load = w_res_from_mem | (w_is_div & (r_state != S_DONE));
  assign fwd_data    = w_result;
endmodule

// File: tb/tb_ex_stage_mc.sv
// Directed bench for ex_stage_mc: results flow through a queue scoreboard,
// handshake, store-lane and divider timing are asserted at each step.
module tb_ex_stage_mc;
  localparam int XLEN  = 32;
  localparam int IN_W  = 4*XLEN+26;
  localparam int OUT_W = 2*XLEN+12;

  localparam logic [11:0] ADD = 12'h001, SUB = 12'h002, SLT = 12'h004;
  localparam logic [11:0] XOR = 12'h080, SRA = 12'h400;

  logic              clk = 1'b0;
  logic              reset, flush, valid_in, allow_out;
  logic [IN_W-1:0]   stage_in;
  logic              allow_in, valid_out;
  logic [OUT_W-1:0]  stage_out;
  logic              data_sram_en;
  logic [XLEN/8-1:0] data_sram_we;
  logic [XLEN-1:0]   data_sram_addr, data_sram_wdata;
  logic              fwd_valid, fwd_is_load;
  logic [4:0]        fwd_dest;
  logic [XLEN-1:0]   fwd_data;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int pulses = 0;
  logic [63:0] sb[$];

  ex_stage_mc #(.XLEN(XLEN)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .valid_in(valid_in), .allow_in(allow_in), .stage_in(stage_in),
    .valid_out(valid_out), .allow_out(allow_out), .stage_out(stage_out),
    .data_sram_en(data_sram_en), .data_sram_we(data_sram_we),
    .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
    .fwd_valid(fwd_valid), .fwd_dest(fwd_dest),
    .fwd_is_load(fwd_is_load), .fwd_data(fwd_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk) if (data_sram_en) pulses++;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && valid_out && allow_out) begin
      if (sb.size() == 0) chk("sb_unexpected_output", stage_out[63:0], 64'hx);
      else chk("sb_result_pc", stage_out[63:0], sb.pop_front());
    end
  end

  function automatic logic [IN_W-1:0] mk(input logic [4:0] dest, input logic [31:0] s1,
      input logic [31:0] s2, input logic [11:0] alu, input logic [2:0] md,
      input logic mwe, input logic [1:0] msz, input logic men,
      input logic [31:0] sd, input logic [31:0] pc);
    logic rf_we;
    rf_we = ~mwe;
    return {rf_we, dest, 1'b0, s1, s2, alu, md, mwe, msz, men, sd, pc};
  endfunction

  task automatic issue(input logic [IN_W-1:0] v, input logic [63:0] exp, input bit track);
    int n;
    n = 0;
    valid_in = 1'b1;
    stage_in = v;
    #1;
    while (!allow_in && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("issue_wait_bound", 64'(n < 100), 64'd1);
    if (track) sb.push_back(exp);
    @(posedge clk); #1;
    valid_in = 1'b0;
  endtask

  task automatic run_div(input logic [IN_W-1:0] v, input logic [31:0] res, input logic [31:0] pc);
    int n, lows;
    issue(v, {res, pc}, 1'b1);
    n = 0;
    lows = 0;
    @(negedge clk);
    chk("div_fwd_is_load", 64'(fwd_is_load), 64'd1);
    while (!valid_out && n < 60) begin
      if (!allow_in) lows++;
      n++;
      @(negedge clk);
    end
    chk("div_latency", 64'(n), 64'(XLEN));
    chk("div_allow_in_low", 64'(lows), 64'(XLEN));
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, p0;
    reset = 1'b1; flush = 1'b0; valid_in = 1'b0; allow_out = 1'b1; stage_in = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_allow_in", 64'(allow_in), 64'd1);
    chk("rst_valid_out", 64'(valid_out), 64'd0);
    chk("rst_stage_out_zero", 64'(stage_out == '0), 64'd1);
    chk("rst_sram_en", 64'(data_sram_en), 64'd0);
    chk("rst_sram_we", 64'(data_sram_we), 64'd0);
    chk("rst_fwd", {62'd0, fwd_valid, fwd_is_load}, 64'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // add, then back-to-back ALU/multiply traffic
    issue(mk(5'd1, 32'd5, 32'd7, ADD, 3'd0, 0, 2'd0, 0, 0, 32'h10), {32'd12, 32'h10}, 1'b1);
    chk("add_valid_out", 64'(valid_out), 64'd1);
    chk("add_allow_in", 64'(allow_in), 64'd1);
    chk("add_fwd", {fwd_valid, fwd_dest, fwd_is_load, fwd_data}, {1'b1, 5'd1, 1'b0, 32'd12});
    c0 = cyc;
    issue(mk(5'd2, 32'd5, 32'd7, SUB, 3'd0, 0, 2'd0, 0, 0, 32'h14), {32'hFFFFFFFE, 32'h14}, 1'b1);
    issue(mk(5'd0, 32'hFFFFFFFF, 32'd1, SLT, 3'd0, 0, 2'd0, 0, 0, 32'h18), {32'd1, 32'h18}, 1'b1);
    chk("dest0_no_fwd", 64'(fwd_valid), 64'd0);
    issue(mk(5'd3, 32'h80000000, 32'd4, SRA, 3'd0, 0, 2'd0, 0, 0, 32'h1C), {32'hF8000000, 32'h1C}, 1'b1);
    issue(mk(5'd4, 32'hF0F0F0F0, 32'hFF00FF00, XOR, 3'd0, 0, 2'd0, 0, 0, 32'h20), {32'h0FF00FF0, 32'h20}, 1'b1);
    issue(mk(5'd5, 32'h80000000, 32'd2, 12'd0, 3'd1, 0, 2'd0, 0, 0, 32'h24), {32'h0, 32'h24}, 1'b1);
    issue(mk(5'd6, 32'h80000000, 32'd2, 12'd0, 3'd2, 0, 2'd0, 0, 0, 32'h28), {32'hFFFFFFFF, 32'h28}, 1'b1);
    issue(mk(5'd7, 32'hFFFFFFFF, 32'hFFFFFFFF, 12'd0, 3'd3, 0, 2'd0, 0, 0, 32'h2C), {32'hFFFFFFFE, 32'h2C}, 1'b1);
    chk("throughput_cycles", 64'(cyc - c0), 64'd7);
    @(posedge clk); #1;

    // store word held by back-pressure, then released
    allow_out = 1'b0;
    p0 = pulses;
    issue(mk(5'd0, 32'h100, 32'd0, ADD, 3'd0, 1, 2'd2, 1, 32'h12345678, 32'h30), {32'h100, 32'h30}, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("hold_sram_en", 64'(data_sram_en), 64'd0);
      chk("hold_allow_in", 64'(allow_in), 64'd0);
      chk("hold_valid_out", 64'(valid_out), 64'd1);
      @(posedge clk); #1;
    end
    allow_out = 1'b1;
    @(negedge clk);
    chk("sw_pulse", {31'd0, data_sram_en, 28'd0, data_sram_we}, {31'd0, 1'b1, 28'd0, 4'hF});
    chk("sw_addr_wdata", {data_sram_addr, data_sram_wdata}, {32'h100, 32'h12345678});
    chk("sw_allow_in", 64'(allow_in), 64'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("sw_pulse_count", 64'(pulses - p0), 64'd1);
    @(posedge clk); #1;

    // divides and their corner cases
    run_div(mk(5'd8, 32'hFFFFFFF9, 32'd2, 12'd0, 3'd4, 0, 2'd0, 0, 0, 32'h40), 32'hFFFFFFFD, 32'h40);
    run_div(mk(5'd8, 32'hFFFFFFF9, 32'd2, 12'd0, 3'd5, 0, 2'd0, 0, 0, 32'h44), 32'hFFFFFFFF, 32'h44);
    run_div(mk(5'd8, 32'd1234, 32'd0, 12'd0, 3'd6, 0, 2'd0, 0, 0, 32'h48), 32'hFFFFFFFF, 32'h48);
    run_div(mk(5'd8, 32'd1234, 32'd0, 12'd0, 3'd7, 0, 2'd0, 0, 0, 32'h4C), 32'd1234, 32'h4C);
    run_div(mk(5'd8, 32'h80000000, 32'hFFFFFFFF, 12'd0, 3'd4, 0, 2'd0, 0, 0, 32'h50), 32'h80000000, 32'h50);
    run_div(mk(5'd8, 32'd100, 32'd7, 12'd0, 3'd7, 0, 2'd0, 0, 0, 32'h54), 32'd2, 32'h54);

    // flush mid-divide, then an add right behind it
    issue(mk(5'd9, 32'd100, 32'd3, 12'd0, 3'd4, 0, 2'd0, 0, 0, 32'h60), 64'd0, 1'b0);
    repeat (9) begin @(posedge clk); #1; end
    flush = 1'b1;
    #1;
    chk("flush_valid_out", 64'(valid_out), 64'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    chk("post_flush_allow_in", 64'(allow_in), 64'd1);
    issue(mk(5'd10, 32'd20, 32'd22, ADD, 3'd0, 0, 2'd0, 0, 0, 32'h64), {32'd42, 32'h64}, 1'b1);
    chk("post_flush_add_valid", {62'd0, valid_out, fwd_is_load}, {62'd0, 1'b1, 1'b0});
    run_div(mk(5'd8, 32'd100, 32'd3, 12'd0, 3'd6, 0, 2'd0, 0, 0, 32'h68), 32'd33, 32'h68);

    // byte store lanes and misaligned half
    issue(mk(5'd0, 32'h200, 32'd3, ADD, 3'd0, 1, 2'd0, 1, 32'h000000AB, 32'h70), {32'h203, 32'h70}, 1'b1);
    chk("stb_en_we", {data_sram_en, data_sram_we}, {1'b1, 4'b1000});
    chk("stb_wdata", 64'(data_sram_wdata), 64'hABABABAB);
    issue(mk(5'd0, 32'h200, 32'd1, ADD, 3'd0, 1, 2'd1, 1, 32'h0000BEEF, 32'h74), {32'h201, 32'h74}, 1'b1);
    chk("sth_ale", 64'(stage_out[2*XLEN]), 64'd1);
    chk("sth_sram_en", 64'(data_sram_en), 64'd0);
    issue(mk(5'd0, 32'h200, 32'd2, ADD, 3'd0, 1, 2'd1, 1, 32'h0000BEEF, 32'h78), {32'h202, 32'h78}, 1'b1);
    chk("sth_hi_lane", {data_sram_en, data_sram_we, data_sram_wdata}, {1'b1, 4'b1100, 32'hBEEFBEEF});

    repeat (4) begin @(posedge clk); #1; end
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
